// File: rtl/fb_port_arbiter.sv
// N-channel write-port arbiter for frame-buffer RAM port A: round-robin sharing,
// channel locking, freeze-drop of masked channels and per-channel frame counting.
// Optional per-channel drop counters are enabled with `define FB_ARB_DROP_CNT_EN.
module fb_port_arbiter #(
   parameter int                ADDR_W       = 19,
   parameter int                DATA_W       = 12,
   parameter int                NUM_CH       = 2,
   parameter int                FRAME_PIXELS = 307200,
   parameter logic [NUM_CH-1:0] FREEZE_MASK  = 'b01
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        wr_req,
   input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
   input  logic [NUM_CH*DATA_W-1:0] wr_data,
   output logic [NUM_CH-1:0]        wr_gnt,
   input  logic [NUM_CH-1:0]        lock_req,
   input  logic                     freeze,
   output logic                     ram_ena,
   output logic                     ram_wea,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_din,
   output logic                     locked,
   output logic [2:0]               lock_owner,
`ifdef FB_ARB_DROP_CNT_EN
   input  logic                     drop_clr,
   output logic [NUM_CH*16-1:0]     drop_cnt,
`endif
   output logic [NUM_CH-1:0]        frame_done
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

   typedef enum logic {
      ST_SHARED,
      ST_LOCKED
   } state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   owner_idx, owner_nxt;
   logic [PTR_W-1:0]   rr_ptr;

   logic [NUM_CH-1:0]  drop_cond;
   logic [NUM_CH-1:0]  gnt;
   logic [NUM_CH-1:0]  xfer;
   logic [NUM_CH-1:0]  dropped;
   logic [NUM_CH-1:0]  wr_hits;

   logic               lock_hit;
   logic [PTR_W-1:0]   lock_idx;
   logic               rr_hit;
   logic [PTR_W-1:0]   rr_idx;
   logic               wr_any;
   logic [PTR_W-1:0]   wr_ch;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   logic [CNT_W-1:0]   frame_cnt [NUM_CH];

   assign drop_cond = FREEZE_MASK & {NUM_CH{freeze}} & wr_req;

   // Lowest-index lock request wins: scan downwards so the last hit is the lowest.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      lock_hit = 1'b0;
      lock_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (lock_req[i]) begin
            lock_hit = 1'b1;
            lock_idx = PTR_W'(i);
         end
      end
   end

   // Round-robin search starting just after the last channel that wrote.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         logic [PTR_W-1:0] cand;
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_CH);
         if (!rr_hit && wr_req[cand] && !drop_cond[cand]) begin
            rr_hit = 1'b1;
            rr_idx = cand;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (!rst) begin
         if (state == ST_SHARED) begin
            gnt = drop_cond;
            if (rr_hit) gnt[rr_idx] = 1'b1;
         end else begin
            gnt[owner_idx] = wr_req[owner_idx];
         end
      end
   end

   assign wr_gnt  = gnt;
   assign xfer    = wr_req & gnt;
   assign dropped = xfer & drop_cond;
   assign wr_hits = xfer & ~drop_cond;
   assign wr_any  = |wr_hits;

   // At most one non-dropped transfer exists per cycle; select its address and data.
   always_comb begin
      wr_ch    = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_hits[i]) begin
            wr_ch    = PTR_W'(i);
            sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
            sel_data = wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner_idx;
      case (state)
         ST_SHARED: begin
            if (lock_hit) begin
               state_nxt = ST_LOCKED;
               owner_nxt = lock_idx;
            end
         end
         ST_LOCKED: begin
            if (!lock_req[owner_idx]) state_nxt = ST_SHARED;
         end
         default: state_nxt = ST_SHARED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state     <= ST_SHARED;
         owner_idx <= '0;
         rr_ptr    <= PTR_W'(NUM_CH - 1);
      end else begin
         state     <= state_nxt;
         owner_idx <= owner_nxt;
         if (state == ST_SHARED && wr_any) rr_ptr <= wr_ch;
      end
   end

   // Write path: one register stage; address and data hold while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_ena  <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
      end else begin
         ram_ena <= wr_any;
         if (wr_any) begin
            ram_addr <= sel_addr;
            ram_din  <= sel_data;
         end
      end
   end

   assign ram_wea    = ram_ena;
   assign locked     = (state == ST_LOCKED);
   assign lock_owner = 3'(owner_idx);

   // Count-based frame tracking; the done pulse lines up with the registered RAM write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done <= '0;
         for (int i = 0; i < NUM_CH; i++) frame_cnt[i] <= '0;
      end else begin
         frame_done <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_hits[i]) begin
               if (frame_cnt[i] == LAST_CNT) begin
                  frame_cnt[i]  <= '0;
                  frame_done[i] <= 1'b1;
               end else begin
                  frame_cnt[i] <= frame_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

`ifdef FB_ARB_DROP_CNT_EN
   logic [15:0] drop_q [NUM_CH];

   // Saturating drop counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) drop_q[i] <= '0;
      end else if (drop_clr) begin
         for (int i = 0; i < NUM_CH; i++) drop_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (dropped[i] && drop_q[i] != 16'hFFFF) drop_q[i] <= drop_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) drop_cnt[i*16 +: 16] = drop_q[i];
   end
`else
   logic unused_dropped;
   assign unused_dropped = |dropped;
`endif

endmodule
